shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier: one control FSM driving a shift/add datapath. It takes two WIDTH-bit operands on a valid strobe and produces a 2·WIDTH-bit product after a fixed WIDTH iterations. It then holds the result until the consumer acknowledges. It sits between an upstream requester (valid/ack handshake) and any consumer of the product; stimulus generation is a bench-only concern.

---
 rtl/mult_pkg.sv | 18 +
 rtl/shift_add_multiplier_if.sv | 22 ++
 rtl/mult_datapath.sv | 50 +++++
 rtl/shift_add_multiplier.sv | 81 ++++++++
 tb/tb_shift_add_multiplier.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle between the requester/consumer and the multiplier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
  logic               iValid_Data;
  logic               iAck;
  logic [WIDTH-1:0]   iData_A;
  logic [WIDTH-1:0]   iData_B;
  logic [2*WIDTH-1:0] oProduct;
  logic               oDone;
  logic               oBusy;

  modport master (
    output iValid_Data, iAck, iData_A, iData_B,
    input  oProduct, oDone, oBusy
  );

  modport slave (
    input  iValid_Data, iAck, iData_A, iData_B,
    output oProduct, oDone, oBusy
  );
endinterface

// File: rtl/mult_datapath.sv
// A/B/P registers with shifters and accumulator; one iteration per cycle.
// No flow control of its own: the FSM selects load, shift/add or hold.
module mult_datapath #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_sel,
  input  logic               b_sel,
  input  logic               prod_sel,
  input  logic               shift_en,
  input  logic               add_en,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               b_lsb,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] p_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
    end else begin
      if (!a_sel)
        a_reg <= {{WIDTH{1'b0}}, data_a};
      else if (shift_en)
        a_reg <= a_reg << 1;

      if (!b_sel)
        b_reg <= data_b;
      else if (shift_en)
        b_reg <= b_reg >> 1;

      // Add uses the pre-shift A, so bit i of B weights A<<i.
      if (!prod_sel)
        p_reg <= '0;
      else if (add_en)
        p_reg <= p_reg + a_reg;
    end
  end

  assign b_lsb   = b_reg[0];
  assign product = p_reg;

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier; result WIDTH edges after the valid edge.
// Result is held in DONE until acknowledged; requests are ignored while busy.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   Clock,
  input logic                   Reset,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          a_sel, b_sel, prod_sel, shift_en, add_en;
  logic          b_lsb;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == MULT)
        cnt <= cnt + CW'(1);
      else if (state == IDLE)
        cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    a_sel     = 1'b1;
    b_sel     = 1'b1;
    prod_sel  = 1'b1;
    shift_en  = 1'b0;
    add_en    = 1'b0;
    unique case (state)
      IDLE: begin
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        prod_sel = 1'b0;
        if (bus.iValid_Data)
          state_nxt = MULT;
      end
      MULT: begin
        shift_en = 1'b1;
        add_en   = b_lsb;
        // Fixed WIDTH iterations, no early exit when B runs out of ones.
        if (cnt == LAST)
          state_nxt = DONE;
      end
      DONE: begin
        if (bus.iAck)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (Clock),
    .rst      (Reset),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .prod_sel (prod_sel),
    .shift_en (shift_en),
    .add_en   (add_en),
    .data_a   (bus.iData_A),
    .data_b   (bus.iData_B),
    .b_lsb    (b_lsb),
    .product  (bus.oProduct)
  );

  assign bus.oDone = (state == DONE);
  assign bus.oBusy = (state == MULT);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed checks of the multiplier against an arithmetic reference.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(32)) bus ();

  shift_add_multiplier #(.WIDTH(32)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One full transaction: request, wait for result, verify, acknowledge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int ack_dly, input bit disturb);
    logic [63:0] want;
    int lat;
    want = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    bus.iData_A = a;
    bus.iData_B = b;
    bus.iValid_Data = 1'b1;
    @(posedge clk); #1;
    bus.iValid_Data = 1'b0;
    lat = 0;
    chk("busy_start", {63'd0, bus.oBusy}, 64'd1);
    while (!bus.oDone && lat < 100) begin
      if (disturb) begin
        bus.iData_A = $urandom;
        bus.iData_B = $urandom;
        bus.iValid_Data = 1'($urandom_range(0, 1));
        bus.iAck = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.iValid_Data = 1'b0;
    bus.iAck = 1'b0;
    chk("latency", 64'(lat), 64'd32);
    chk("product", bus.oProduct, want);
    chk("busy_end", {63'd0, bus.oBusy}, 64'd0);
    repeat (ack_dly) @(posedge clk);
    #1;
    chk("hold_done", {63'd0, bus.oDone}, 64'd1);
    chk("hold_product", bus.oProduct, want);
    bus.iAck = 1'b1;
    @(posedge clk); #1;
    bus.iAck = 1'b0;
    chk("ack_done_low", {63'd0, bus.oDone}, 64'd0);
    chk("ack_product_kept", bus.oProduct, want);
    @(posedge clk); #1;
    chk("product_cleared", bus.oProduct, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int last_done;
    int n_done;
    bit done_prev;
    bus.iValid_Data = 1'b0;
    bus.iAck = 1'b0;
    bus.iData_A = '0;
    bus.iData_B = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", bus.oProduct, 64'd0);
    chk("rst_done", {63'd0, bus.oDone}, 64'd0);
    chk("rst_busy", {63'd0, bus.oBusy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd10, 32'd16, 5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(32'd0, 32'h1234_5678, 0, 1'b0);
    run_op(32'h1234_5678, 32'd0, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, int'($urandom_range(0, 4)), 1'b0);
    run_op($urandom, $urandom, 3, 1'b1);
    run_op(32'hDEAD_BEEF, 32'h8000_0001, 0, 1'b1);

    // Abort 7x9 at iteration 15 with reset.
    @(negedge clk);
    bus.iData_A = 32'd7;
    bus.iData_B = 32'd9;
    bus.iValid_Data = 1'b1;
    @(posedge clk); #1;
    bus.iValid_Data = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.oDone) seen++;
    end
    rst = 1'b1;
    #1;
    chk("abort_done", {63'd0, bus.oDone}, 64'd0);
    chk("abort_busy", {63'd0, bus.oBusy}, 64'd0);
    chk("abort_product", bus.oProduct, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.oDone) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run_op(32'd3, 32'd5, 1, 1'b0);

    // Continuous valid and ack: back-to-back operations.
    @(negedge clk);
    bus.iData_A = 32'd7;
    bus.iData_B = 32'd6;
    bus.iValid_Data = 1'b1;
    bus.iAck = 1'b1;
    last_done = -1;
    n_done = 0;
    done_prev = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk); #1;
      if (done_prev)
        chk("b2b_done_width", {63'd0, bus.oDone}, 64'd0);
      if (bus.oDone) begin
        n_done++;
        chk("b2b_product", bus.oProduct, 64'd42);
        if (last_done >= 0)
          chk("b2b_period", 64'(cyc - last_done), 64'd34);
        last_done = cyc;
      end
      done_prev = bus.oDone;
    end
    chk("b2b_count", 64'(n_done >= 4), 64'd1);
    bus.iValid_Data = 1'b0;
    repeat (40) @(posedge clk);
    bus.iAck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
